// File: rtl/tft_spi_tx_if.sv
// Client-side handshake for the TFT SPI transmitter.
//   tft_transmit : one-cycle request strobe (client -> transmitter)
//   tft_dc       : 0 = command byte, 1 = data byte, sampled with the strobe
//   tft_data     : byte to send, sampled with the strobe
//   tft_busy     : high while a byte is in flight (transmitter -> client)
// The client may strobe only when both tft_busy and tft_transmit are low.
interface tft_spi_tx_if;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;

  modport master (
    output tft_transmit,
    output tft_dc,
    output tft_data,
    input  tft_busy
  );

  modport slave (
    input  tft_transmit,
    input  tft_dc,
    input  tft_data,
    output tft_busy
  );
endinterface

// File: rtl/tft_spi_tx.sv
// Byte serialiser for the TFT controller's 4-wire SPI bus (SPI mode 0, MSB first).
// One byte per request. CS is held low for CS_HOLD idle cycles after each byte so
// back-to-back bytes from the drawing clients share a single CS assertion.
//
// Parameters:
//   CLK_DIV : clk cycles per SCK half-period (1..255)
//   CS_HOLD : idle clk cycles CS stays low after a byte; 0 = release after every byte
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : client handshake (tft_transmit / tft_dc / tft_data in, tft_busy out)
//   spi_sck  : SPI clock, idles low
//   spi_mosi : serial data, changes only at accept or on SCK falling edges
//   spi_cs   : chip select, active low
//   spi_dc   : display DC pin, updated only when a byte is accepted
// All outputs come straight from flops.
module tft_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  tft_spi_tx_if.slave bus,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs,
  output logic        spi_dc
);

  localparam int unsigned DivW  = $clog2(CLK_DIV + 1);
  localparam int unsigned HoldW = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [HoldW-1:0] HoldLast = (CS_HOLD > 0) ? HoldW'(CS_HOLD - 1) : '0;
  localparam bit               HoldEn   = (CS_HOLD > 0);

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StGap,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  // MOSI is the MSB of the shift register, so it is registered without a separate flop.
  logic [7:0]        shift_q, shift_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              dc_q, dc_d;
  logic              busy_q, busy_d;

  logic div_last;
  logic accept;

  assign div_last = (div_q == DivLast);
  // Requests are only seen when nothing is in flight; strobes while busy are dropped.
  assign accept   = bus.tft_transmit && ((state_q == StIdle) || (state_q == StHold));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          // A request in HOLD wins over the CS release, so CS never blips high.
          shift_d = bus.tft_data;
          dc_d    = bus.tft_dc;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          hold_d  = '0;
          state_d = StLow;
        end else if (state_q == StHold) begin
          if (hold_q == HoldLast) begin
            cs_d    = 1'b1;
            hold_d  = '0;
            state_d = StIdle;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end

      StLow: begin
        if (div_last) begin
          sck_d   = 1'b1;
          div_d   = '0;
          state_d = StHigh;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StHigh: begin
        if (div_last) begin
          sck_d = 1'b0;
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StGap;
          end else begin
            // Next bit appears on the falling edge, stable through the next high phase.
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            state_d = StLow;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StGap: begin
        // SCK held low for one extra half-period before the byte is declared done.
        if (div_last) begin
          div_d  = '0;
          busy_d = 1'b0;
          if (HoldEn) begin
            hold_d  = '0;
            state_d = StHold;
          end else begin
            cs_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tft_busy = busy_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = shift_q[7];
  assign spi_cs       = cs_q;
  assign spi_dc       = dc_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
module tb_tft_spi_tx;

  localparam int DivA  = 2;
  localparam int HoldA = 4;
  localparam int DivB  = 1;
  localparam int HoldB = 0;
  localparam int Bound = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tft_spi_tx_if if_a ();
  tft_spi_tx_if if_b ();

  logic sck_a, mosi_a, cs_a, dc_a;
  logic sck_b, mosi_b, cs_b, dc_b;

  tft_spi_tx #(.CLK_DIV(DivA), .CS_HOLD(HoldA)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (if_a),
    .spi_sck  (sck_a),
    .spi_mosi (mosi_a),
    .spi_cs   (cs_a),
    .spi_dc   (dc_a)
  );

  tft_spi_tx #(.CLK_DIV(DivB), .CS_HOLD(HoldB)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (if_b),
    .spi_sck  (sck_b),
    .spi_mosi (mosi_b),
    .spi_cs   (cs_b),
    .spi_dc   (dc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI slave monitors: sample MOSI on each SCK rise while CS is low.
  logic [8:0] rx_a[$];
  logic [8:0] rx_b[$];
  int   pulses_a = 0, pulses_b = 0, cs_rise_a = 0, cs_rise_b = 0, cnt_a = 0, cnt_b = 0;
  logic prev_sck_a = 1'b0, prev_cs_a = 1'b1, prev_sck_b = 1'b0, prev_cs_b = 1'b1;
  logic [7:0] sh_a = '0, sh_b = '0;

  always @(negedge clk) begin
    prev_sck_a <= sck_a;
    prev_cs_a  <= cs_a;
    if (sck_a && !prev_sck_a) pulses_a <= pulses_a + 1;
    if (cs_a && !prev_cs_a) begin
      cs_rise_a <= cs_rise_a + 1;
      cnt_a     <= 0;
    end else if (sck_a && !prev_sck_a && !cs_a) begin
      sh_a <= {sh_a[6:0], mosi_a};
      if (cnt_a == 7) begin
        rx_a.push_back({dc_a, sh_a[6:0], mosi_a});
        cnt_a <= 0;
      end else begin
        cnt_a <= cnt_a + 1;
      end
    end
  end

  always @(negedge clk) begin
    prev_sck_b <= sck_b;
    prev_cs_b  <= cs_b;
    if (sck_b && !prev_sck_b) pulses_b <= pulses_b + 1;
    if (cs_b && !prev_cs_b) begin
      cs_rise_b <= cs_rise_b + 1;
      cnt_b     <= 0;
    end else if (sck_b && !prev_sck_b && !cs_b) begin
      sh_b <= {sh_b[6:0], mosi_b};
      if (cnt_b == 7) begin
        rx_b.push_back({dc_b, sh_b[6:0], mosi_b});
        cnt_b <= 0;
      end else begin
        cnt_b <= cnt_b + 1;
      end
    end
  end

  // {busy, sck, mosi, cs, dc}
  function automatic logic [4:0] outs(input int which);
    if (which == 0) return {if_a.tft_busy, sck_a, mosi_a, cs_a, dc_a};
    return {if_b.tft_busy, sck_b, mosi_b, cs_b, dc_b};
  endfunction

  // Expected pins n clock edges after the accept edge, from the timing rules of a byte.
  function automatic logic [4:0] model_at(input int n, input int d, input int h,
                                          input logic dcv, input logic [7:0] b);
    logic bsy, sck, cs;
    int   j;
    bsy = (n < 17 * d);
    sck = 1'b0;
    for (int k = 0; k < 8; k++)
      if (n >= d * (1 + 2 * k) && n < d * (2 + 2 * k)) sck = 1'b1;
    j = n / (2 * d);
    if (j > 7) j = 7;
    cs = (n >= 17 * d + h);
    return {bsy, sck, b[7-j], cs, dcv};
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic strobe(input int which, input logic dcv, input logic [7:0] b);
    if (which == 0) begin
      if_a.tft_transmit = 1'b1; if_a.tft_dc = dcv; if_a.tft_data = b;
    end else begin
      if_b.tft_transmit = 1'b1; if_b.tft_dc = dcv; if_b.tft_data = b;
    end
    @(negedge clk);
    if (which == 0) if_a.tft_transmit = 1'b0;
    else            if_b.tft_transmit = 1'b0;
  endtask

  task automatic wait_idle(input int which, input string name);
    int t = 0;
    while (outs(which)[4] && t < Bound) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, 32'(t >= Bound), 32'd0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic exact_run(input int which, input logic dcv, input logic [7:0] b,
                           input string tag);
    int d, h;
    d = (which == 0) ? DivA : DivB;
    h = (which == 0) ? HoldA : HoldB;
    strobe(which, dcv, b);
    for (int n = 0; n <= 17 * d + h + 2; n++) begin
      check($sformatf("%s_n%0d", tag, n), 32'(outs(which)), 32'(model_at(n, d, h, dcv, b)));
      @(negedge clk);
    end
  endtask

  task automatic expect_rx(input int which, input logic [8:0] exp, input string name);
    int sz;
    sz = (which == 0) ? rx_a.size() : rx_b.size();
    if (sz == 0) begin
      check({name, "_rx_empty"}, 32'd0, 32'd1);
    end else if (which == 0) begin
      check(name, 32'(rx_a.pop_front()), 32'(exp));
    end else begin
      check(name, 32'(rx_b.pop_front()), 32'(exp));
    end
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] data;
    logic [8:0] exp_rx;
    int         exp_busy;
    int         exp_pulses;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [8:0] exp_q[$];
    logic [7:0] cli_data[5];
    logic       cli_dc[5];
    int p0, c0, len, t, d, r;
    logic       dv;
    logic [7:0] bv;

    vecs[0] = '{dc: 1'b0, data: 8'h2C, exp_rx: 9'h02C, exp_busy: 34, exp_pulses: 8};
    vecs[1] = '{dc: 1'b1, data: 8'hFF, exp_rx: 9'h1FF, exp_busy: 34, exp_pulses: 8};
    vecs[2] = '{dc: 1'b1, data: 8'h00, exp_rx: 9'h100, exp_busy: 34, exp_pulses: 8};
    vecs[3] = '{dc: 1'b0, data: 8'h80, exp_rx: 9'h080, exp_busy: 34, exp_pulses: 8};
    vecs[4] = '{dc: 1'b1, data: 8'h01, exp_rx: 9'h101, exp_busy: 34, exp_pulses: 8};
    vecs[5] = '{dc: 1'b0, data: 8'h5A, exp_rx: 9'h05A, exp_busy: 34, exp_pulses: 8};
    cli_data = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h1A};
    cli_dc   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    if_a.tft_transmit = 1'b0; if_a.tft_dc = 1'b0; if_a.tft_data = '0;
    if_b.tft_transmit = 1'b0; if_b.tft_dc = 1'b0; if_b.tft_data = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Idle after reset: busy=0, sck=0, mosi=0, cs=1, dc=0.
    for (int i = 0; i < 20; i++) begin
      check($sformatf("reset_idle_a_%0d", i), 32'(outs(0)), 32'b00010);
      check($sformatf("reset_idle_b_%0d", i), 32'(outs(1)), 32'b00010);
      @(negedge clk);
    end

    // Cycle-exact single command byte.
    exact_run(0, 1'b0, 8'h2A, "exact_2a");
    idle(2);
    expect_rx(0, 9'h02A, "exact_2a_rx");

    // Cycle-exact fast divider with no CS hold.
    exact_run(1, 1'b1, 8'h55, "exact_55_b");
    idle(2);
    expect_rx(1, 9'h155, "exact_55_b_rx");

    // Table of single bytes.
    foreach (vecs[i]) begin
      p0 = pulses_a;
      strobe(0, vecs[i].dc, vecs[i].data);
      len = 0;
      while (if_a.tft_busy && len < Bound) begin
        @(negedge clk);
        len++;
      end
      idle(3);
      check($sformatf("vec%0d_busy_len", i), 32'(len), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_pulses", i), 32'(pulses_a - p0), 32'(vecs[i].exp_pulses));
      expect_rx(0, vecs[i].exp_rx, $sformatf("vec%0d_rx", i));
    end
    idle(10);

    // Drawing-client burst: CS must stay low across all five bytes.
    c0 = cs_rise_a;
    foreach (cli_data[i]) begin
      wait_idle(0, $sformatf("client%0d", i));
      strobe(0, cli_dc[i], cli_data[i]);
    end
    wait_idle(0, "client_end");
    @(negedge clk);
    check("client_cs_cont", 32'(cs_rise_a - c0), 32'd0);
    idle(8);
    check("client_cs_release", 32'(cs_rise_a - c0), 32'd1);
    foreach (cli_data[i]) expect_rx(0, {cli_dc[i], cli_data[i]}, $sformatf("client_rx%0d", i));

    // Strobe while busy is dropped.
    idle(4);
    p0 = pulses_a;
    strobe(0, 1'b0, 8'h81);
    idle(9);
    strobe(0, 1'b1, 8'hFF);
    wait_idle(0, "ignore");
    idle(10);
    check("ignore_pulses", 32'(pulses_a - p0), 32'd8);
    expect_rx(0, 9'h081, "ignore_rx");
    check("ignore_no_extra", 32'(rx_a.size()), 32'd0);

    // Reset during bit 3 aborts the byte.
    p0 = pulses_a;
    strobe(0, 1'b1, 8'hA5);
    t = 0;
    while (pulses_a - p0 < 4 && t < Bound) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_bit3_timeout", 32'(t >= Bound), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", 32'(cs_a), 32'd1);
    check("abort_sck", 32'(sck_a), 32'd0);
    check("abort_busy", 32'(if_a.tft_busy), 32'd0);
    rst = 1'b0;
    idle(3);
    exact_run(0, 1'b0, 8'hC3, "after_abort_c3");
    idle(2);
    expect_rx(0, 9'h0C3, "after_abort_rx");
    check("after_abort_no_partial", 32'(rx_a.size()), 32'd0);

    // Random traffic with stray strobes while busy, against an ordered byte list.
    for (int w = 0; w < 2; w++) begin
      d = (w == 0) ? DivA : DivB;
      exp_q.delete();
      for (int i = 0; i < 30; i++) begin
        wait_idle(w, $sformatf("rand%0d_%0d", w, i));
        idle($urandom_range(0, 6));
        dv = 1'($urandom_range(0, 1));
        bv = 8'($urandom);
        strobe(w, dv, bv);
        exp_q.push_back({dv, bv});
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(1, 17 * d - 3);
          idle(r);
          strobe(w, 1'($urandom_range(0, 1)), 8'($urandom));
        end
      end
      wait_idle(w, $sformatf("rand%0d_end", w));
      idle(10);
      check($sformatf("rand%0d_count", w),
            32'((w == 0) ? rx_a.size() : rx_b.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) expect_rx(w, exp_q[i], $sformatf("rand%0d_rx%0d", w, i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
